// File: rtl/hft_order_pkg.sv
// Shared order types, scheduler states and ITCH stock symbol constants.
// Used by order_tx_scheduler and the outbound ITCH formatter.
package hft_order_pkg;

  typedef enum logic {
    BUY  = 1'b0,
    SELL = 1'b1
  } trade_t;

  typedef enum logic [1:0] {
    AAPL  = 2'd0,
    AMZN  = 2'd1,
    GOOGL = 2'd2,
    MSFT  = 2'd3
  } stock_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  // Eight-character, space-padded ITCH stock field.
  localparam logic [63:0] SYM_AAPL  = "AAPL    ";
  localparam logic [63:0] SYM_AMZN  = "AMZN    ";
  localparam logic [63:0] SYM_GOOGL = "GOOGL   ";
  localparam logic [63:0] SYM_MSFT  = "MSFT    ";

  function automatic logic [63:0] stock_ascii(input stock_t s);
    logic [63:0] sym;
    case (s)
      AAPL:    sym = SYM_AAPL;
      AMZN:    sym = SYM_AMZN;
      GOOGL:   sym = SYM_GOOGL;
      default: sym = SYM_MSFT;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/order_tx_scheduler_if.sv
// Lane request bus and presented-order bus of the order scheduler.
// master = strategy lanes / order book side, slave = scheduler.
interface order_tx_scheduler_if #(
  parameter int NUM_LANES = 4,
  parameter int REG_WIDTH = 32
);
  logic [NUM_LANES-1:0]           i_req_valid;
  logic [NUM_LANES-1:0]           o_req_ready;
  logic [NUM_LANES-1:0]           i_req_trade_type;
  logic [NUM_LANES*16-1:0]        i_req_quantity;
  logic [NUM_LANES*REG_WIDTH-1:0] i_req_buy_price;
  logic [NUM_LANES*REG_WIDTH-1:0] i_req_sell_price;
  logic                           i_book_is_busy;
  logic                           o_valid;
  logic [NUM_LANES-1:0]           o_grant;
  logic [1:0]                     o_stock_symbol;
  logic                           o_trade_type;
  logic [15:0]                    o_quantity;
  logic [REG_WIDTH-1:0]           o_buy_price;
  logic [REG_WIDTH-1:0]           o_sell_price;
  logic [REG_WIDTH-1:0]           o_order_id;
  logic [REG_WIDTH-1:0]           o_timestamp;

  modport master (
    output i_req_valid, i_req_trade_type, i_req_quantity, i_req_buy_price,
           i_req_sell_price, i_book_is_busy,
    input  o_req_ready, o_valid, o_grant, o_stock_symbol, o_trade_type,
           o_quantity, o_buy_price, o_sell_price, o_order_id, o_timestamp
  );

  modport slave (
    input  i_req_valid, i_req_trade_type, i_req_quantity, i_req_buy_price,
           i_req_sell_price, i_book_is_busy,
    output o_req_ready, o_valid, o_grant, o_stock_symbol, o_trade_type,
           o_quantity, o_buy_price, o_sell_price, o_order_id, o_timestamp
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, cyclic.
module rr_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);
  int lane;

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    idx  = '0;
    lane = 0;
    for (int off = NUM_LANES - 1; off >= 0; off--) begin
      lane = (int'(ptr) + off) % NUM_LANES;
      if (req[lane]) begin
        idx = IDX_W'(lane);
      end
    end
  end

  assign any = |req;

  always_comb begin
    grant = '0;
    if (any) begin
      grant[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/order_tx_scheduler.sv
// Round-robin add-order scheduler feeding the ITCH formatter; issues order ids and timestamps.
// Optional accept-rate limiting is enabled with `define ORDER_RATE_LIMIT_EN.
module order_tx_scheduler
  import hft_order_pkg::*;
#(
  parameter int                   NUM_LANES     = 4,
  parameter int                   REG_WIDTH     = 32,
  parameter logic [REG_WIDTH-1:0] ORDER_ID_BASE = 32'h0000_0001
`ifdef ORDER_RATE_LIMIT_EN
  ,
  parameter int                   MIN_GAP_CYCLES = 8
`endif
) (
  input logic               i_clk,
  input logic               i_rst,
  order_tx_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LANES);

  sched_state_t         state_reg, state_next;
  logic [IDX_W-1:0]     ptr_reg;
  logic [REG_WIDTH-1:0] order_cnt_reg;
  logic [REG_WIDTH-1:0] ts_cnt_reg;

  logic                 valid_reg;
  logic [NUM_LANES-1:0] grant_reg;
  logic [IDX_W-1:0]     idx_reg;
  trade_t               trade_reg;
  logic [15:0]          qty_reg;
  logic [REG_WIDTH-1:0] buy_reg, sell_reg, id_reg, ts_reg;

  logic [NUM_LANES-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [NUM_LANES-1:0] ready;
  logic                 capture, accept;

  logic [15:0]          lane_qty  [NUM_LANES];
  logic [REG_WIDTH-1:0] lane_buy  [NUM_LANES];
  logic [REG_WIDTH-1:0] lane_sell [NUM_LANES];

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_qty[gi]  = bus.i_req_quantity[16*gi +: 16];
      assign lane_buy[gi]  = bus.i_req_buy_price[REG_WIDTH*gi +: REG_WIDTH];
      assign lane_sell[gi] = bus.i_req_sell_price[REG_WIDTH*gi +: REG_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req   (bus.i_req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

`ifdef ORDER_RATE_LIMIT_EN
  // GAP covers the spacing not already spent in IDLE and ISSUE.
  localparam int           GAP_LOAD     = (MIN_GAP_CYCLES > 2) ? MIN_GAP_CYCLES - 2 : 0;
  localparam sched_state_t AFTER_ACCEPT = (GAP_LOAD > 0) ? GAP : IDLE;
  logic [31:0] gap_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_cnt_reg <= '0;
    end else if (accept) begin
      gap_cnt_reg <= 32'(GAP_LOAD);
    end else if (state_reg == GAP && gap_cnt_reg != 32'd0) begin
      gap_cnt_reg <= gap_cnt_reg - 32'd1;
    end
  end
`else
  localparam sched_state_t AFTER_ACCEPT = IDLE;
`endif

  always_comb begin
    state_next = state_reg;
    ready      = '0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          ready      = arb_grant;
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.i_book_is_busy) begin
          accept     = 1'b1;
          state_next = AFTER_ACCEPT;
        end
      end
`ifdef ORDER_RATE_LIMIT_EN
      GAP: begin
        if (gap_cnt_reg <= 32'd1) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      order_cnt_reg <= ORDER_ID_BASE;
      ts_cnt_reg    <= '0;
      valid_reg     <= 1'b0;
      grant_reg     <= '0;
      idx_reg       <= '0;
      trade_reg     <= BUY;
      qty_reg       <= '0;
      buy_reg       <= '0;
      sell_reg      <= '0;
      id_reg        <= '0;
      ts_reg        <= '0;
    end else begin
      state_reg  <= state_next;
      ts_cnt_reg <= ts_cnt_reg + 1'b1;
      if (capture) begin
        valid_reg <= 1'b1;
        grant_reg <= arb_grant;
        idx_reg   <= arb_idx;
        trade_reg <= trade_t'(bus.i_req_trade_type[arb_idx]);
        qty_reg   <= lane_qty[arb_idx];
        buy_reg   <= lane_buy[arb_idx];
        sell_reg  <= lane_sell[arb_idx];
        id_reg    <= order_cnt_reg;
        ts_reg    <= ts_cnt_reg;
      end
      if (accept) begin
        valid_reg     <= 1'b0;
        order_cnt_reg <= order_cnt_reg + 1'b1;
        ptr_reg       <= (idx_reg == IDX_W'(NUM_LANES - 1)) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // No lane may see a ready pulse while reset is held.
  assign bus.o_req_ready    = i_rst ? '0 : ready;
  assign bus.o_valid        = valid_reg;
  assign bus.o_grant        = grant_reg;
  assign bus.o_stock_symbol = 2'(idx_reg);
  assign bus.o_trade_type   = trade_reg;
  assign bus.o_quantity     = qty_reg;
  assign bus.o_buy_price    = buy_reg;
  assign bus.o_sell_price   = sell_reg;
  assign bus.o_order_id     = id_reg;
  assign bus.o_timestamp    = ts_reg;
endmodule

// File: tb/tb_order_tx_scheduler.sv
// Directed bench for order_tx_scheduler: reset, RR order, stall, wrap, mid-order reset, id wrap.
// Spacing and GAP expectations follow ORDER_RATE_LIMIT_EN when it is defined.
module tb_order_tx_scheduler;
  localparam int NL = 4;
  localparam int RW = 32;
`ifdef ORDER_RATE_LIMIT_EN
  localparam int EXP_SPACING = 8;
`else
  localparam int EXP_SPACING = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   onset_cyc = 0;
  int   prev_onset = 0;

  always #5 clk = ~clk;

  order_tx_scheduler_if #(.NUM_LANES(NL), .REG_WIDTH(RW)) bus ();
  order_tx_scheduler_if #(.NUM_LANES(NL), .REG_WIDTH(RW)) bus2 ();

  order_tx_scheduler #(
    .NUM_LANES     (NL),
    .REG_WIDTH     (RW),
    .ORDER_ID_BASE (32'h0000_0001)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  order_tx_scheduler #(
    .NUM_LANES     (NL),
    .REG_WIDTH     (RW),
    .ORDER_ID_BASE (32'hFFFF_FFFF)
  ) dut_wrap (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Wait (bounded) for a presented order, check it, then let it be accepted.
  task automatic await_order(input string tag, input logic [3:0] exp_grant, input logic [31:0] exp_id);
    int w;
    w = 0;
    while (bus.o_valid !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    check({tag, "_seen"}, 64'(w < 40), 64'd1);
    check({tag, "_grant"}, bus.o_grant, exp_grant);
    check({tag, "_sym"}, bus.o_stock_symbol, onehot_idx(exp_grant));
    check({tag, "_id"}, bus.o_order_id, exp_id);
    check({tag, "_ready_in_issue"}, bus.o_req_ready, 4'b0000);
    onset_cyc = cyc;
    step();
  endtask

  initial begin
    bus.i_req_valid       = '0;
    bus.i_req_trade_type  = '0;
    bus.i_req_quantity    = '0;
    bus.i_req_buy_price   = '0;
    bus.i_req_sell_price  = '0;
    bus.i_book_is_busy    = 1'b0;
    bus2.i_req_valid      = '0;
    bus2.i_req_trade_type = '0;
    bus2.i_req_quantity   = '0;
    bus2.i_req_buy_price  = '0;
    bus2.i_req_sell_price = '0;
    bus2.i_book_is_busy   = 1'b0;

    // Reset state, with a request pending to show ready stays low in reset
    rst = 1'b1;
    bus.i_req_valid = 4'b0010;
    step();
    step();
    check("rst_ready", bus.o_req_ready, 4'b0000);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_grant", bus.o_grant, 4'b0000);
    check("rst_id", bus.o_order_id, 32'h0);
    check("rst_ts", bus.o_timestamp, 32'h0);

    // Single lane-1 order
    bus.i_req_valid = 4'b0000;
    rst = 1'b0;
    step();
    bus.i_req_valid      = 4'b0010;
    bus.i_req_trade_type = 4'b0000;
    bus.i_req_quantity   = {16'h0, 16'h0, 16'h01BB, 16'h0};
    bus.i_req_buy_price  = {32'h0, 32'h0, 32'h0000_BABB, 32'h0};
    bus.i_req_sell_price = {32'h0, 32'h0, 32'h0000_BABC, 32'h0};
    #1;
    check("t1_ready_pulse", bus.o_req_ready, 4'b0010);
    step();
    bus.i_req_valid = 4'b0000;
    check("t1_valid", bus.o_valid, 1'b1);
    check("t1_grant", bus.o_grant, 4'b0010);
    check("t1_sym", bus.o_stock_symbol, 2'd1);
    check("t1_id", bus.o_order_id, 32'd1);
    check("t1_ts", bus.o_timestamp, 32'd1);
    check("t1_qty", bus.o_quantity, 16'h01BB);
    check("t1_buy", bus.o_buy_price, 32'h0000_BABB);
    check("t1_sell", bus.o_sell_price, 32'h0000_BABC);
    check("t1_side", bus.o_trade_type, 1'b0);
    step();
    check("t1_drop", bus.o_valid, 1'b0);
    check("t1_hold_id", bus.o_order_id, 32'd1);
    check("t1_hold_sym", bus.o_stock_symbol, 2'd1);

    // All four lanes held valid: 0,1,2,3,0 with ids 1..5
    do_reset();
    bus.i_req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      await_order("rr", 4'b0001 << (n % 4), 32'(n + 1));
      if (n > 0) check("rr_spacing", 64'(onset_cyc - prev_onset), 64'(EXP_SPACING));
      prev_onset = onset_cyc;
      check("rr_drop", bus.o_valid, 1'b0);
    end

    // Lane 2 stalled by a busy book for 10 cycles
    do_reset();
    bus.i_book_is_busy   = 1'b1;
    bus.i_req_valid      = 4'b0100;
    bus.i_req_trade_type = 4'b0100;
    bus.i_req_quantity   = {16'h0, 16'h0222, 16'h0, 16'h0};
    bus.i_req_sell_price = {32'h0, 32'h2222_0002, 32'h0, 32'h0};
    step();
    bus.i_req_valid    = 4'b0001;
    bus.i_req_quantity = '0;
    for (int i = 0; i < 10; i++) begin
      check("st_valid", bus.o_valid, 1'b1);
      check("st_id", bus.o_order_id, 32'd1);
      check("st_qty", bus.o_quantity, 16'h0222);
      check("st_ready", bus.o_req_ready, 4'b0000);
      step();
    end
    check("st_sym", bus.o_stock_symbol, 2'd2);
    check("st_side", bus.o_trade_type, 1'b1);
    check("st_sell", bus.o_sell_price, 32'h2222_0002);
    bus.i_book_is_busy = 1'b0;
    step();
    check("st_accepted", bus.o_valid, 1'b0);
    await_order("st_next", 4'b0001, 32'd2);

    // Pointer 3 then wrap to lane 0
    do_reset();
    bus.i_req_valid = 4'b0100;
    await_order("wr_a", 4'b0100, 32'd1);
    bus.i_req_valid = 4'b1001;
    await_order("wr_b", 4'b1000, 32'd2);
    await_order("wr_c", 4'b0001, 32'd3);

    // Reset while an order is stalled in ISSUE
    do_reset();
    bus.i_req_valid = 4'b0100;
    await_order("rs_a", 4'b0100, 32'd1);
    bus.i_req_valid    = 4'b0010;
    bus.i_book_is_busy = 1'b1;
    step();
    check("rs_pending", bus.o_valid, 1'b1);
    rst = 1'b1;
    step();
    check("rs_valid", bus.o_valid, 1'b0);
    check("rs_id", bus.o_order_id, 32'd0);
    check("rs_ready", bus.o_req_ready, 4'b0000);
    rst = 1'b0;
    bus.i_book_is_busy = 1'b0;
    bus.i_req_valid    = 4'b1010;
    await_order("rs_b", 4'b0010, 32'd1);

`ifdef ORDER_RATE_LIMIT_EN
    // No activity on the bus while the gap runs
    do_reset();
    bus.i_req_valid = 4'b0001;
    await_order("gp_a", 4'b0001, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("gp_ready", bus.o_req_ready, 4'b0000);
      check("gp_valid", bus.o_valid, 1'b0);
      step();
    end
    check("gp_resume_ready", bus.o_req_ready, 4'b0001);
`endif

    // Order number wraps from all-ones to zero
    bus.i_req_valid = 4'b0000;
    do_reset();
    bus2.i_req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      int w;
      w = 0;
      while (bus2.o_valid !== 1'b1 && w < 40) begin
        step();
        w++;
      end
      check("idw_seen", 64'(w < 40), 64'd1);
      check("idw_id", bus2.o_order_id, (k == 0) ? 32'hFFFF_FFFF : 32'h0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/order_tx_scheduler.md
Name: order_tx_scheduler

Overview:
- Arbitrates outgoing add-order requests from NUM_LANES strategy lanes, one lane per stock symbol (lane index equals the 2-bit stock code: 0 AAPL, 1 AMZN, 2 GOOGL, 3 MSFT).
- Presents one order at a time to the outbound ITCH order formatter, using round-robin fairness.
- Generates the unique order number and the timestamp that the formatter currently hardcodes.
- Holds each order stable until the order book is not busy.

Parameters:
- NUM_LANES, 4, number of requesting lanes; lane index is the stock code. Fixed at 4 for the 2-bit symbol.
- REG_WIDTH, 32, width of price, order-number and timestamp fields.
- ORDER_ID_BASE, 32'h0000_0001, first order number issued after reset.
- MIN_GAP_CYCLES, 8, minimum cycles between accepted orders. Used only with ORDER_RATE_LIMIT_EN.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  NUM_LANES  per-lane order request.
- o_req_ready  out  NUM_LANES  per-lane accept pulse (one-hot or zero).
- i_req_trade_type  in  NUM_LANES  per-lane side (0 BUY, 1 SELL).
- i_req_quantity  in  NUM_LANES*16  packed per-lane quantity; lane k at [16k+15:16k].
- i_req_buy_price  in  NUM_LANES*REG_WIDTH  packed per-lane buy quote.
- i_req_sell_price  in  NUM_LANES*REG_WIDTH  packed per-lane sell quote.
- i_book_is_busy  in  1  downstream stall; order accepted on a cycle where o_valid=1 and i_book_is_busy=0.
- o_valid  out  1  order presented.
- o_grant  out  NUM_LANES  one-hot lane of the presented order.
- o_stock_symbol  out  2  encoded lane index.
- o_trade_type  out  1  captured side.
- o_quantity  out  16  captured quantity.
- o_buy_price  out  REG_WIDTH  captured buy quote.
- o_sell_price  out  REG_WIDTH  captured sell quote.
- o_order_id  out  REG_WIDTH  unique order number.
- o_timestamp  out  REG_WIDTH  timestamp captured at grant.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - RR pointer=0, order counter=ORDER_ID_BASE, timestamp counter=0, gap counter=0.
  - Reset mid-ISSUE discards the pending order. No ready pulse is issued while i_rst=1.
- Timestamp counter: free-running, +1 every cycle out of reset, wraps 2^REG_WIDTH-1 -> 0.
- FSM states:
  - IDLE:
    - If any i_req_valid is set, grant lane k = first requesting lane at or after the pointer, cyclic search (pointer=2, req=4'b0011 grants lane 0).
    - o_req_ready[k]=1 combinationally in that same cycle; the lane's request is consumed.
    - At the edge, capture the lane fields, o_order_id=order counter, o_timestamp=timestamp counter, and o_grant/o_stock_symbol.
    - Set o_valid=1 and go to ISSUE.
  - ISSUE:
    - o_req_ready=0; outputs held stable.
    - If i_book_is_busy=0: accept. Next cycle o_valid=0 and other outputs keep their last values. Order counter +1 (wraps modulo 2^REG_WIDTH). Pointer=(k+1) mod NUM_LANES (3 wraps to 0). Go to IDLE, or to GAP with the feature enabled.
    - If i_book_is_busy=1: stay in ISSUE indefinitely.
  - GAP (feature only): described under Optional Feature.
- Latency and throughput:
  - Request to o_valid: 1 cycle.
  - Peak throughput: 1 order per 2 cycles (IDLE and ISSUE alternate).
- A lane deasserting i_req_valid after its ready pulse does not affect the captured order.
- A lane holding i_req_valid after acceptance is re-arbitrated normally.
- Simultaneous requests are served strictly in RR order; no lane waits more than NUM_LANES grants.

Optional Feature:
- Macro ORDER_RATE_LIMIT_EN.
- Defined:
  - After each acceptance, enter GAP with gap counter=MIN_GAP_CYCLES-2.
  - Decrement each cycle; return to IDLE when it reaches 0.
  - Accepted-to-accepted spacing is at least MIN_GAP_CYCLES cycles.
  - o_req_ready=0 and o_valid=0 throughout GAP.
  - MIN_GAP_CYCLES<=2 behaves as no gap.
- Undefined: the GAP state and its counter are absent, and ISSUE always returns to IDLE.

Decomposition:
- Shared package hft_order_pkg holds:
  - trade_t (BUY=0, SELL=1) and stock_t (AAPL..MSFT).
  - sched_state_t (IDLE, ISSUE, GAP).
  - The ASCII symbol constants the formatter uses.
- One sub-module is natural: rr_arbiter. It takes the request vector and pointer, and returns the one-hot grant, the encoded index and an any-request flag. It is purely combinational and reusable.

Test Plan:
- Reset, then lane 1 valid (BUY, qty 16'h01BB, buy 32'hBABB), busy=0 -> ready[1] pulse in cycle 0; cycle 1 shows o_valid=1, symbol=1, order_id=1, timestamp=1; cycle 2 shows o_valid=0.
- All four lanes held valid, busy=0 -> grants 0,1,2,3,0 in order; order_id 1..5; o_valid pulses every 2 cycles.
- Lane 2 granted while busy=1 for 10 cycles -> o_valid and all fields stable for 10 cycles with no ready pulses; accepted on the first busy=0 cycle; order_id increments exactly once.
- Pointer=3, req=4'b1001 after a lane-3 grant -> lane 0 granted (wrap). Order counter forced to 32'hFFFF_FFFF -> next order_id is 0.
- i_rst asserted during ISSUE -> next cycle o_valid=0, next grant carries order_id=ORDER_ID_BASE and pointer restarts at 0.
- ORDER_RATE_LIMIT_EN with MIN_GAP_CYCLES=8, constant request -> accepts spaced exactly 8 cycles apart; no ready pulse during GAP.
